// File: rtl/cv32e40p_mult_retry_ctrl.sv
// -----------------------------------------------------------------------------
// cv32e40p_mult_retry_ctrl
//
// Sits between the EX stage and the TMR-hardened multiplier. Requests pass
// straight through while idle (no added latency) and the operands are captured
// at the same time. If the multiplier completes with its voter fault flag
// set, the controller drains the multiplier, stalls EX and replays the
// operation from the captured operands. Up to MAX_RETRY replays are made; the
// result of the last permitted attempt is accepted even if it is faulty, and
// uncorrectable_o then marks that result. Faulty completions are counted in a
// saturating counter.
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   req_valid_i          multiply request from EX
//   operator_i, op_*_i   operator and operands from EX
//   ex_ready_i           EX can take the result
//   ready_o, result_o    result handshake towards EX (result_o is 0 unless ready_o)
//   mult_*_o             request, operands and ex_ready towards the multiplier
//   mult_ready_i         multiplier completion (voted)
//   mult_fault_i         multiplier voter fault
//   mult_result_i        multiplier voted result
//   stall_o              replay in progress, EX must hold
//   uncorrectable_o      pulse with the accepted handshake of a faulty last attempt
//   fault_cnt_o          saturating count of faulty completions
//   fault_cnt_clr_i      synchronous clear of the fault counter (wins over increment)
// -----------------------------------------------------------------------------
module cv32e40p_mult_retry_ctrl #(
    parameter int MAX_RETRY = 2,
    parameter int CNT_W     = 8,
    parameter int OP_W      = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    input  logic [OP_W-1:0]   operator_i,
    input  logic [31:0]       op_a_i,
    input  logic [31:0]       op_b_i,
    input  logic [31:0]       op_c_i,
    input  logic              ex_ready_i,
    output logic              ready_o,
    output logic [31:0]       result_o,
    output logic              mult_enable_o,
    output logic [OP_W-1:0]   mult_operator_o,
    output logic [31:0]       mult_op_a_o,
    output logic [31:0]       mult_op_b_o,
    output logic [31:0]       mult_op_c_o,
    output logic              mult_ex_ready_o,
    input  logic              mult_ready_i,
    input  logic              mult_fault_i,
    input  logic [31:0]       mult_result_i,
    output logic              stall_o,
    output logic              uncorrectable_o,
    output logic [CNT_W-1:0]  fault_cnt_o,
    input  logic              fault_cnt_clr_i
);

    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RW-1:0]    RETRY_LIMIT = RW'(MAX_RETRY);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        REPLAY = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [RW-1:0]     retry_reg, retry_next;
    logic [CNT_W-1:0]  fault_cnt_reg, fault_cnt_next;

    logic [OP_W-1:0]   operator_reg;
    logic [31:0]       op_a_reg;
    logic [31:0]       op_b_reg;
    logic [31:0]       op_c_reg;

    logic              capture;
    logic              active;
    logic              completion;
    logic              good;
    logic              accept;
    logic              fault_inc;

    // -------------------------------------------------------------------------
    // Next state, handshakes and operand mux
    // -------------------------------------------------------------------------
    always_comb begin
        state_next      = state_reg;
        retry_next      = retry_reg;
        ready_o         = 1'b0;
        result_o        = 32'd0;
        mult_ex_ready_o = 1'b0;
        stall_o         = 1'b0;
        uncorrectable_o = 1'b0;
        fault_inc       = 1'b0;

        capture    = (state_reg == IDLE) && req_valid_i;
        active     = (state_reg != IDLE) || req_valid_i;
        completion = active && mult_ready_i;
        good       = !mult_fault_i;
        accept     = good || (retry_reg == RETRY_LIMIT);

        if (state_reg == IDLE) begin
            mult_enable_o   = req_valid_i;
            mult_operator_o = operator_i;
            mult_op_a_o     = op_a_i;
            mult_op_b_o     = op_b_i;
            mult_op_c_o     = op_c_i;
        end else begin
            mult_enable_o   = 1'b1;
            mult_operator_o = operator_reg;
            mult_op_a_o     = op_a_reg;
            mult_op_b_o     = op_b_reg;
            mult_op_c_o     = op_c_reg;
        end

        if (completion) begin
            if (accept) begin
                ready_o         = 1'b1;
                result_o        = mult_result_i;
                mult_ex_ready_o = ex_ready_i;
                uncorrectable_o = !good && ex_ready_i;
                // A faulty result still waiting for EX is counted only once,
                // at the cycle EX actually takes it.
                fault_inc       = !good && ex_ready_i;
                if (ex_ready_i) begin
                    state_next = IDLE;
                    retry_next = '0;
                end
            end else begin
                // Drain the faulty result out of the multiplier and replay.
                mult_ex_ready_o = 1'b1;
                stall_o         = 1'b1;
                fault_inc       = 1'b1;
                retry_next      = retry_reg + RW'(1);
                state_next      = REPLAY;
            end
        end else if (state_reg == IDLE && req_valid_i) begin
            state_next = BUSY;
        end

        // The accepted completion of a replay releases EX in the same cycle.
        if (state_reg == REPLAY && !ready_o) begin
            stall_o = 1'b1;
        end

        if (fault_cnt_clr_i) begin
            fault_cnt_next = '0;
        end else if (fault_inc && fault_cnt_reg != CNT_MAX) begin
            fault_cnt_next = fault_cnt_reg + CNT_W'(1);
        end else begin
            fault_cnt_next = fault_cnt_reg;
        end
    end

    assign fault_cnt_o = fault_cnt_reg;

    // -------------------------------------------------------------------------
    // State, retry and counter registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            retry_reg     <= '0;
            fault_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            retry_reg     <= retry_next;
            fault_cnt_reg <= fault_cnt_next;
        end
    end

    // Operand capture; replays always reuse these values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            operator_reg <= '0;
            op_a_reg     <= '0;
            op_b_reg     <= '0;
            op_c_reg     <= '0;
        end else if (capture) begin
            operator_reg <= operator_i;
            op_a_reg     <= op_a_i;
            op_b_reg     <= op_b_i;
            op_c_reg     <= op_c_i;
        end
    end

endmodule

// File: tb/tb_cv32e40p_mult_retry_ctrl.sv
module tb_cv32e40p_mult_retry_ctrl;

    localparam int MAX_RETRY = 2;
    localparam int CNT_W     = 8;
    localparam int OP_W      = 3;
    localparam int CNT_SAT   = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid_i = 1'b0;
    logic [OP_W-1:0]   operator_i = '0;
    logic [31:0]       op_a_i = '0, op_b_i = '0, op_c_i = '0;
    logic              ex_ready_i = 1'b0;
    logic              ready_o;
    logic [31:0]       result_o;
    logic              mult_enable_o;
    logic [OP_W-1:0]   mult_operator_o;
    logic [31:0]       mult_op_a_o, mult_op_b_o, mult_op_c_o;
    logic              mult_ex_ready_o;
    logic              mult_ready_i = 1'b0;
    logic              mult_fault_i = 1'b0;
    logic [31:0]       mult_result_i = '0;
    logic              stall_o;
    logic              uncorrectable_o;
    logic [CNT_W-1:0]  fault_cnt_o;
    logic              fault_cnt_clr_i = 1'b0;

    int  n_vec  = 0;
    int  n_err  = 0;
    int  m_cnt  = 0;      // reference fault counter
    bit  clr_en = 1'b1;   // random clears allowed
    bit  clr_force = 1'b0;
    int  n_txn  = 0;

    always #5 clk = ~clk;

    cv32e40p_mult_retry_ctrl #(
        .MAX_RETRY(MAX_RETRY), .CNT_W(CNT_W), .OP_W(OP_W)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .operator_i(operator_i),
        .op_a_i(op_a_i), .op_b_i(op_b_i), .op_c_i(op_c_i),
        .ex_ready_i(ex_ready_i),
        .ready_o(ready_o), .result_o(result_o),
        .mult_enable_o(mult_enable_o), .mult_operator_o(mult_operator_o),
        .mult_op_a_o(mult_op_a_o), .mult_op_b_o(mult_op_b_o), .mult_op_c_o(mult_op_c_o),
        .mult_ex_ready_o(mult_ex_ready_o),
        .mult_ready_i(mult_ready_i), .mult_fault_i(mult_fault_i), .mult_result_i(mult_result_i),
        .stall_o(stall_o), .uncorrectable_o(uncorrectable_o),
        .fault_cnt_o(fault_cnt_o), .fault_cnt_clr_i(fault_cnt_clr_i)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: inputs already driven; check outputs at the falling
    // edge, then advance the reference counter across the rising edge.
    task automatic do_cycle(input bit e_rdy, input logic [31:0] e_res, input bit e_mexr,
                            input bit e_stall, input bit e_unc, input bit e_en,
                            input logic [OP_W-1:0] e_op, input logic [31:0] ea,
                            input logic [31:0] eb, input logic [31:0] ec, input bit inc);
        bit clr;
        clr = clr_force || (clr_en && $urandom_range(0, 15) == 0);
        fault_cnt_clr_i = clr;
        @(negedge clk);
        check("ready", 32'(ready_o), 32'(e_rdy));
        check("result", result_o, e_res);
        check("mult_ex_ready", 32'(mult_ex_ready_o), 32'(e_mexr));
        check("stall", 32'(stall_o), 32'(e_stall));
        check("uncorrectable", 32'(uncorrectable_o), 32'(e_unc));
        check("mult_enable", 32'(mult_enable_o), 32'(e_en));
        check("mult_operator", 32'(mult_operator_o), 32'(e_op));
        check("mult_op_a", mult_op_a_o, ea);
        check("mult_op_b", mult_op_b_o, eb);
        check("mult_op_c", mult_op_c_o, ec);
        check("fault_cnt", 32'(fault_cnt_o), 32'(m_cnt));
        if (clr) m_cnt = 0;
        else if (inc && m_cnt < CNT_SAT) m_cnt++;
        @(posedge clk);
        #1;
    endtask

    // Live inputs: held at the request while the controller is still idle,
    // scrambled afterwards to prove the captured operands are used.
    task automatic drive_req(input bit in_idle, input logic [OP_W-1:0] opr,
                             input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        if (in_idle) begin
            req_valid_i = 1'b1;
            operator_i = opr; op_a_i = a; op_b_i = b; op_c_i = c;
        end else begin
            req_valid_i = 1'($urandom);
            operator_i = OP_W'($urandom);
            op_a_i = $urandom; op_b_i = $urandom; op_c_i = $urandom;
        end
    endtask

    // One request. lat = wait cycles before each attempt completes,
    // fm = fault flag of each attempt, hold = cycles EX holds off the result.
    task automatic run_txn(input logic [OP_W-1:0] opr, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] c,
                           input int lat0, input int lat1, input int lat2,
                           input logic [2:0] fm, input int hold);
        int lat[3];
        bit in_idle;
        bit acc;
        logic [31:0] res;
        int k;
        lat[0] = lat0; lat[1] = lat1; lat[2] = lat2;
        in_idle = 1'b1;
        acc = 1'b0;
        k = 0;
        while (!acc && k <= MAX_RETRY) begin
            acc = !fm[k] || (k == MAX_RETRY);
            res = fm[k] ? ((a * b) ^ 32'hDEAD_BEEF) : (a * b);
            for (int w = 0; w <= lat[k]; w++) begin
                if (w < lat[k]) begin
                    drive_req(in_idle, opr, a, b, c);
                    mult_ready_i = 1'b0; mult_fault_i = 1'($urandom);
                    mult_result_i = $urandom; ex_ready_i = 1'($urandom);
                    do_cycle(0, 0, 0, k > 0, 0, 1, opr, a, b, c, 0);
                    in_idle = 1'b0;
                end else if (acc) begin
                    for (int h = 0; h <= hold; h++) begin
                        drive_req(in_idle, opr, a, b, c);
                        mult_ready_i = 1'b1; mult_fault_i = fm[k];
                        mult_result_i = res; ex_ready_i = (h == hold);
                        do_cycle(1, res, h == hold, 0, (h == hold) && fm[k], 1,
                                 opr, a, b, c, (h == hold) && fm[k]);
                    end
                end else begin
                    drive_req(in_idle, opr, a, b, c);
                    mult_ready_i = 1'b1; mult_fault_i = 1'b1;
                    mult_result_i = res; ex_ready_i = 1'($urandom);
                    do_cycle(0, 0, 1, 1, 0, 1, opr, a, b, c, 1);
                    in_idle = 1'b0;
                end
            end
            k++;
        end
        // Idle gap: nothing is active, the multiplier sees the live inputs.
        req_valid_i = 1'b0;
        operator_i = OP_W'($urandom);
        op_a_i = $urandom; op_b_i = $urandom; op_c_i = $urandom;
        mult_ready_i = 1'($urandom); mult_fault_i = 1'($urandom);
        mult_result_i = $urandom; ex_ready_i = 1'($urandom);
        do_cycle(0, 0, 0, 0, 0, 0, operator_i, op_a_i, op_b_i, op_c_i, 0);
        n_txn++;
        $display("txn %0d: op=%0d a=%0h b=%0h lat=%0d/%0d/%0d faults=%b hold=%0d cnt=%0d",
                 n_txn, opr, a, b, lat0, lat1, lat2, fm, hold, m_cnt);
    endtask

    initial begin
        // Reset state
        #2;
        check("rst_ready", 32'(ready_o), 0);
        check("rst_stall", 32'(stall_o), 0);
        check("rst_enable", 32'(mult_enable_o), 0);
        check("rst_fault_cnt", 32'(fault_cnt_o), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed cases
        clr_en = 1'b0;
        run_txn(3'd0, 32'd7, 32'd6, 32'd0, 0, 0, 0, 3'b000, 0);   // 42, single cycle
        run_txn(3'd0, 32'd3, 32'd5, 32'd0, 0, 1, 0, 3'b001, 0);   // one replay, 15
        run_txn(3'd0, 32'd9, 32'd9, 32'd1, 1, 0, 2, 3'b111, 0);   // uncorrectable
        run_txn(3'd1, 32'h8000_0001, 32'h7FFF_FFFF, 32'd0, 3, 0, 0, 3'b000, 4); // held result
        run_txn(3'd0, 32'd11, 32'd13, 32'd0, 0, 0, 0, 3'b000, 3); // held while idle

        // Randomized traffic
        clr_en = 1'b1;
        for (int t = 0; t < 150; t++) begin
            run_txn(OP_W'($urandom), $urandom, $urandom, $urandom,
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    3'($urandom), $urandom_range(0, 2) == 0 ? $urandom_range(1, 4) : 0);
        end

        // Saturation, then clear together with a fault
        clr_en = 1'b0;
        while (m_cnt < CNT_SAT)
            run_txn(3'd0, $urandom, $urandom, 32'd0, 0, 0, 0, 3'b111, 0);
        run_txn(3'd0, 32'd2, 32'd2, 32'd0, 0, 0, 0, 3'b111, 0);
        check("sat_hold", 32'(fault_cnt_o), CNT_SAT);
        clr_force = 1'b1;
        run_txn(3'd0, 32'd4, 32'd4, 32'd0, 0, 0, 0, 3'b001, 0);
        clr_force = 1'b0;
        check("clr_wins", 32'(fault_cnt_o), 0);

        // Reset in the middle of a replay
        drive_req(1'b1, 3'd0, 32'd5, 32'd6, 32'd0);
        mult_ready_i = 1'b1; mult_fault_i = 1'b1; mult_result_i = 32'h1234; ex_ready_i = 1'b1;
        do_cycle(0, 0, 1, 1, 0, 1, 3'd0, 32'd5, 32'd6, 32'd0, 1);
        req_valid_i = 1'b0; mult_ready_i = 1'b0; mult_fault_i = 1'b0;
        op_a_i = 32'hA5A5_0001; op_b_i = 32'h0F0F_0002; op_c_i = 32'h3;
        #2;
        check("replay_stall", 32'(stall_o), 1);
        rst = 1'b1;
        #1;
        m_cnt = 0;
        check("arst_stall", 32'(stall_o), 0);
        check("arst_ready", 32'(ready_o), 0);
        check("arst_enable", 32'(mult_enable_o), 0);
        check("arst_fault_cnt", 32'(fault_cnt_o), 0);
        check("arst_passthru", mult_op_a_o, 32'hA5A5_0001);
        @(posedge clk); #1;
        rst = 1'b0;
        // A full two-replay sequence proves the retry count restarted at 0.
        run_txn(3'd2, 32'd21, 32'd2, 32'd7, 0, 1, 0, 3'b111, 0);
        run_txn(3'd0, 32'd7, 32'd6, 32'd0, 0, 0, 0, 3'b000, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/cv32e40p_mult_retry_ctrl.md
Name: cv32e40p_mult_retry_ctrl

Overview:
- Sequencing controller between the EX stage and the TMR-hardened multiplier.
- Forwards multiply requests and captures the operands.
- When the multiplier completes with its voter fault flag set, the controller drains the multiplier, stalls EX and replays the operation from the captured operands, up to MAX_RETRY times.
- Tracks fault events in a saturating counter and flags uncorrectable operations.

Parameters:
MAX_RETRY, 2, replays allowed after a faulty completion (0 = never replay; the first result is accepted).
CNT_W, 8, width of the saturating fault event counter.
OP_W, 3, width of the multiplier operator field.

Ports:
clk  input  1  clock
rst  input  1  asynchronous reset, active-high
req_valid_i  input  1  EX requests a multiply (mult enable from EX)
operator_i  input  OP_W  multiply operator
op_a_i  input  32  operand A
op_b_i  input  32  operand B
op_c_i  input  32  operand C
ex_ready_i  input  1  EX stage can accept the result
ready_o  output  1  result valid and accepted towards EX
result_o  output  32  result to EX
mult_enable_o  output  1  enable to multiplier
mult_operator_o  output  OP_W  operator to multiplier
mult_op_a_o  output  32  operand A to multiplier
mult_op_b_o  output  32  operand B to multiplier
mult_op_c_o  output  32  operand C to multiplier
mult_ex_ready_o  output  1  ex_ready to multiplier
mult_ready_i  input  1  multiplier ready (voted)
mult_fault_i  input  1  multiplier voter fault
mult_result_i  input  32  multiplier voted result
stall_o  output  1  replay in progress; EX must hold
uncorrectable_o  output  1  1-cycle pulse with ready_o when the last permitted attempt also faulted
fault_cnt_o  output  CNT_W  saturating count of faulty completions
fault_cnt_clr_i  input  1  synchronous clear of fault_cnt_o

Behaviour:
- Reset: state IDLE; retry_cnt = 0; fault_cnt_o = 0; capture registers = 0. All outputs 0 except mult_* data, which mirror the inputs while in IDLE. Reset mid-operation aborts immediately to IDLE.
- States: IDLE, BUSY, REPLAY.
- Operand mux:
  - IDLE: mult_*_o = live inputs and mult_enable_o = req_valid_i, so there is zero added latency.
  - BUSY/REPLAY: mult_*_o = captured registers and mult_enable_o = 1.
- Capture: in IDLE with req_valid_i = 1, latch operator_i, op_a_i, op_b_i and op_c_i.
- Completion event = mult_ready_i = 1 in any active cycle (IDLE with req_valid_i, BUSY, REPLAY). Let good = !mult_fault_i and accept = good | (retry_cnt == MAX_RETRY).
  - accept:
    - ready_o = 1, result_o = mult_result_i, mult_ex_ready_o = ex_ready_i.
    - If ex_ready_i = 1: go to IDLE, retry_cnt = 0.
    - If ex_ready_i = 0: hold the state with ready_o held; the multiplier keeps its result.
    - uncorrectable_o = accept & !good & ex_ready_i.
  - !accept (faulty completion, retries remain):
    - ready_o = 0, mult_ex_ready_o = 1 (drains the multiplier), stall_o = 1.
    - retry_cnt++; next state REPLAY; the multiplier restarts next cycle.
- No completion:
  - IDLE with req_valid_i → BUSY.
  - BUSY/REPLAY stay.
  - mult_ex_ready_o = 0.
- stall_o = 1 in REPLAY and in any faulty !accept cycle. ready_o is never 1 while stall_o = 1.
- result_o is 0 whenever ready_o = 0.
- req_valid_i dropping in BUSY/REPLAY is ignored: the operation finishes on captured operands.
- Fault counter:
  - Increments on every completion cycle with mult_fault_i = 1 and ex-acceptance or drain (counted once per attempt).
  - Saturates at 2^CNT_W−1.
  - fault_cnt_clr_i has priority over an increment in the same cycle (result 0).
- MAX_RETRY = 0: every completion is accepted; faulty ones pulse uncorrectable_o.

Test Plan:
- Single-cycle MUL, op_a = 7, op_b = 6, no fault, ex_ready_i = 1 → ready_o in the same cycle as req_valid_i, result_o = 42, no stall, fault_cnt_o = 0.
- Fault injected on the first completion only, op_a = 3, op_b = 5 → drain cycle with mult_ex_ready_o = 1 and stall_o = 1, REPLAY, then ready_o with result_o = 15; fault_cnt_o = 1, uncorrectable_o = 0.
- Fault on all 3 attempts with MAX_RETRY = 2 → two replays, then ready_o on the third completion with uncorrectable_o pulsed; fault_cnt_o = 3.
- Multicycle MULH with ex_ready_i = 0 for 4 cycles at completion → ready_o held high with a stable result_o; IDLE one cycle after ex_ready_i rises.
- Preload fault_cnt_o to 255 (CNT_W = 8), inject a fault → stays 255. Assert fault_cnt_clr_i together with a fault → 0.
- Assert rst during REPLAY (retry_cnt = 1) → IDLE, all outputs 0. The next request starts with retry_cnt = 0 and live operand passthrough.
